dct_idct_8pt_pipeline: RTL and testbench
========================================

Name: dct_idct_8pt_pipeline

Overview:
- Streaming 8-point 1-D orthonormal DCT-II / IDCT (DCT-III) engine with fixed-point coefficients.
- Accepts one indexed sample per cycle, collects a frame of 8, then emits 8 transformed values, one per cycle, each tagged with its index.
- Used as the row/column transform primitive in the level-5 image pipeline.

Parameters:
- DATA_W, 12: input sample width, signed two's complement.
- COEFF_W, 16: cosine coefficient width, signed, Q(COEFF_W-2) fractional format (Q1.14 at default).
- OUT_W, 18: output width, signed two's complement.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sample_in  in  DATA_W  signed input sample (DCT: x[n]; IDCT: X[k]).
- valid_in  in  1  sample_in/index/mode qualify this cycle.
- mode  in  1  0 = forward DCT, 1 = inverse DCT.
- index  in  3  slot (n or k) of sample_in within the frame.
- coeff_out  out  OUT_W  signed transformed value.
- valid_out  out  1  coeff_out/index_out valid this cycle.
- index_out  out  3  slot (k for DCT, n for IDCT) of coeff_out.

Behaviour:
- Reset (rst=0, async): valid_out=0, coeff_out=0, index_out=0, input buffer cleared to 0, output sequencer idle, all pipeline valids cleared. Reset mid-frame or mid-output aborts the frame; no further outputs.
- Capture: on each edge with valid_in=1, buffer[index] <= sample_in. Indices may arrive in any order; unwritten slots keep their previous value.
- Frame close: an accepted sample with index==7 closes the frame, at capture edge E.
  - On edge E, the complete buffer (including this sample) and mode are snapshotted into a working frame. Mode is taken from the index-7 cycle.
  - The input buffer stays writable, so the next frame may start on the cycle after E.
- Output sequencing: outputs j=0..7 are issued into a 3-stage pipeline on consecutive edges E+1..E+8.
  - Stage 1: 8 products, working[m] * C.
  - Stage 2: adder-tree sum plus rounding.
  - Stage 3: saturation into the output register.
- Output timing: valid_out=1 with index_out=j for the cycle following edge E+3+j. This gives 8 consecutive valid cycles in ascending index order, then valid_out=0.
- Coefficients: C[k][n] = round(c(k)·cos((2n+1)kπ/16)·2^(COEFF_W-2)), with c(0)=sqrt(1/8) and c(k>0)=1/2. At default: 5793 for k=0; 8035 for k=1, n=0.
- DCT: y[k] = Σn C[k][n]·x[n]. IDCT: y[n] = Σk C[k][n]·X[k] (transposed matrix).
- Arithmetic:
  - Products are DATA_W+COEFF_W bits; the accumulator is DATA_W+COEFF_W+3 bits.
  - Round half-up: add 2^(COEFF_W-3), then arithmetic shift right by COEFF_W-2.
  - Saturate to signed OUT_W range.
- Back-to-back frames:
  - A second frame closing at E' ≥ E+8 must not overlap its outputs with the first frame's.
  - If a frame closes while the sequencer is still busy (E' < E+8), the new snapshot replaces the working frame and sequencing restarts at index 0. The old frame's remaining outputs are dropped; outputs already in the pipeline still drain.
- Round trip: DCT followed by IDCT reconstructs the input within ±1 LSB when the DCT outputs fit in DATA_W bits.

Decomposition:
- Shared package dct8_pkg holds:
  - N=8 constant;
  - the 8×8 coefficient table as COEFF_W-parameterised localparams/function;
  - the rounding shift constant;
  - the mode encoding (MODE_DCT=0, MODE_IDCT=1).
- One natural sub-module, dct8_dot8: 8 signed multipliers, adder tree, round/saturate, 3-stage pipelined, carrying valid and index alongside the data.
- The top level holds the capture buffer, snapshot, sequencer and coefficient select (row k for DCT, column n for IDCT).

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-stream → valid_out=0, coeff_out=0, index_out=0; no output after release until a new index-7 sample.
- DC frame, DCT: 8×100, idx 0..7 → outputs idx0=283, idx1..7=0. First valid 4 cycles after index-7 capture; 8 consecutive cycles.
- DC frame, IDCT: [283,0,0,0,0,0,0,0], mode=1 → all 8 outputs = 100.
- Ramp frame, DCT: x=0..7 → idx0=10, idx1=−6 (0x3FFFA); round-trip IDCT of the 12-bit-truncated results returns 0..7 ±1.
- Out-of-order and negative inputs: send idx 3,0,1,2,4,5,6,7 with −2048 everywhere → idx0=−5793 (0x3E95F), others 0; output still in index order 0..7.
- Saturation: DATA_W=12, OUT_W=12, all samples 2047 → idx0 saturates to 2047.

Source files
------------

// File: rtl/dct8_pkg.sv
// Shared constants for the 8-point DCT/IDCT engine: frame size, mode
// encoding, sequencer states and the cosine coefficient generator.
package dct8_pkg;

    localparam int N           = 8;
    localparam int COEFF_W_DEF = 16;
    localparam int RND_SHIFT   = COEFF_W_DEF - 2;

    localparam logic MODE_DCT  = 1'b0;
    localparam logic MODE_IDCT = 1'b1;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    // sqrt(1/8) in Q1.30, used for every n of row 0
    localparam longint DC_Q30 = 64'sd379625062;

    // 0.5*cos(m*pi/16) in Q1.30 for m = 0..8
    function automatic longint half_cos_q30(input int m);
        longint v;
        case (m)
            0:       v = 64'sd536870912;
            1:       v = 64'sd526555088;
            2:       v = 64'sd496004047;
            3:       v = 64'sd446391848;
            4:       v = 64'sd379625062;
            5:       v = 64'sd298269500;
            6:       v = 64'sd205451611;
            7:       v = 64'sd104738318;
            default: v = 64'sd0;
        endcase
        return v;
    endfunction

    // Fractional bits of a coefficient of the given width (Q1.(w-2))
    function automatic int rnd_shift(input int coeff_w);
        return coeff_w - 2;
    endfunction

    // C[k][n] rounded to Q1.(coeff_w-2); the angle (2n+1)k*pi/16 is folded
    // into the first quadrant and the sign re-applied afterwards.
    function automatic int coeff_val(input int k, input int n, input int coeff_w);
        int     m;
        int     sh;
        logic   neg;
        longint mag;
        m   = ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (m > 16) begin
            m = 32 - m;
        end
        if (m > 8) begin
            neg = 1'b1;
            m   = 16 - m;
        end
        if (k == 0) begin
            mag = DC_Q30;
        end else begin
            mag = half_cos_q30(m);
        end
        sh  = 30 - rnd_shift(coeff_w);
        mag = (mag + (64'sd1 <<< (sh - 1))) >>> sh;
        return neg ? -int'(mag) : int'(mag);
    endfunction

endpackage

// File: rtl/dct_idct_8pt_pipeline_if.sv
// Sample-in / coefficient-out bus of the DCT/IDCT engine.
interface dct_idct_8pt_pipeline_if #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 18
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     valid_in;
    logic                     mode;
    logic [2:0]               index;
    logic signed [OUT_W-1:0]  coeff_out;
    logic                     valid_out;
    logic [2:0]               index_out;

    modport master (
        output sample_in, valid_in, mode, index,
        input  coeff_out, valid_out, index_out
    );

    modport slave (
        input  sample_in, valid_in, mode, index,
        output coeff_out, valid_out, index_out
    );
endinterface

// File: rtl/dct8_dot8.sv
// 3-stage pipelined 8-term dot product: multiply, adder tree with rounding
// offset, then shift and saturate into the output register. Valid and
// index travel alongside the data.
module dct8_dot8 #(
    parameter int DATA_W  = 12,
    parameter int COEFF_W = 16,
    parameter int OUT_W   = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [2:0]                in_index,
    input  logic signed [DATA_W-1:0]  x [8],
    input  logic signed [COEFF_W-1:0] c [8],
    output logic                      out_valid,
    output logic [2:0]                out_index,
    output logic signed [OUT_W-1:0]   out_value
);
    import dct8_pkg::*;

    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ACC_W  = PROD_W + 3;
    localparam int SHIFT  = rnd_shift(COEFF_W);

    localparam logic signed [ACC_W-1:0] RND =
        $signed({{(ACC_W-1){1'b0}}, 1'b1} << (COEFF_W - 3));
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [PROD_W-1:0] prod_r [N];
    logic                     v1_r;
    logic [2:0]               i1_r;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  sum_r;
    logic                     v2_r;
    logic [2:0]               i2_r;
    logic signed [ACC_W-1:0]  shifted_s;
    logic signed [OUT_W-1:0]  sat_s;

    // Stage 1: eight signed products
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int m = 0; m < N; m++) prod_r[m] <= '0;
            v1_r <= 1'b0;
            i1_r <= 3'd0;
        end else begin
            for (int m = 0; m < N; m++) prod_r[m] <= x[m] * c[m];
            v1_r <= in_valid;
            i1_r <= in_index;
        end
    end

    // Adder tree over sign-extended products plus the half-LSB rounding offset
    always_comb begin
        sum_s = RND;
        for (int m = 0; m < N; m++) begin
            sum_s = sum_s + ACC_W'(prod_r[m]);
        end
    end

    // Stage 2: register the rounded sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_r <= '0;
            v2_r  <= 1'b0;
            i2_r  <= 3'd0;
        end else begin
            sum_r <= sum_s;
            v2_r  <= v1_r;
            i2_r  <= i1_r;
        end
    end

    // Drop the fractional bits and clamp to the signed output range
    always_comb begin
        shifted_s = sum_r >>> SHIFT;
        if (shifted_s > OUT_MAX) begin
            sat_s = OUT_MAX[OUT_W-1:0];
        end else if (shifted_s < OUT_MIN) begin
            sat_s = OUT_MIN[OUT_W-1:0];
        end else begin
            sat_s = shifted_s[OUT_W-1:0];
        end
    end

    // Stage 3: output register; the value only moves on valid results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_index <= 3'd0;
            out_value <= '0;
        end else begin
            out_valid <= v2_r;
            if (v2_r) begin
                out_index <= i2_r;
                out_value <= sat_s;
            end
        end
    end

endmodule

// File: rtl/dct_idct_8pt_pipeline.sv
// Streaming 8-point DCT-II / DCT-III engine: indexed capture buffer, frame
// snapshot on the index-7 sample, output sequencer and coefficient select
// feeding the pipelined dot-product unit.
module dct_idct_8pt_pipeline #(
    parameter int DATA_W  = 12,
    parameter int COEFF_W = 16,
    parameter int OUT_W   = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    dct_idct_8pt_pipeline_if.slave  bus
);
    import dct8_pkg::*;

    logic signed [DATA_W-1:0]  buffer_r  [N];
    logic signed [DATA_W-1:0]  working_r [N];
    logic                      work_mode_r;
    seq_state_e                state_r;
    seq_state_e                state_s;
    logic [2:0]                seq_idx_r;
    logic [2:0]                seq_idx_s;
    logic                      issue_s;
    logic                      frame_close_s;
    logic signed [COEFF_W-1:0] coeff_tab [N][N];
    logic signed [COEFF_W-1:0] coeff_sel_s [N];

    assign frame_close_s = bus.valid_in && (bus.index == 3'd7);

    for (genvar gk = 0; gk < N; gk++) begin : g_row
        for (genvar gn = 0; gn < N; gn++) begin : g_col
            assign coeff_tab[gk][gn] = COEFF_W'(coeff_val(gk, gn, COEFF_W));
        end
    end

    // Capture buffer: any accepted sample lands in its slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int m = 0; m < N; m++) buffer_r[m] <= '0;
        end else if (bus.valid_in) begin
            buffer_r[bus.index] <= bus.sample_in;
        end
    end

    // Snapshot the full frame (including the closing sample) and its mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int m = 0; m < N; m++) working_r[m] <= '0;
            work_mode_r <= MODE_DCT;
        end else if (frame_close_s) begin
            for (int m = 0; m < N - 1; m++) working_r[m] <= buffer_r[m];
            working_r[N-1] <= bus.sample_in;
            work_mode_r    <= bus.mode;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= SEQ_IDLE;
            seq_idx_r <= 3'd0;
        end else begin
            state_r   <= state_s;
            seq_idx_r <= seq_idx_s;
        end
    end

    // Sequencer: issue one output per cycle; a new frame restarts at 0
    always_comb begin
        state_s   = state_r;
        seq_idx_s = seq_idx_r;
        issue_s   = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (frame_close_s) begin
                    state_s   = SEQ_RUN;
                    seq_idx_s = 3'd0;
                end else begin
                    state_s   = SEQ_IDLE;
                end
            end
            SEQ_RUN: begin
                issue_s = 1'b1;
                if (frame_close_s) begin
                    seq_idx_s = 3'd0;
                end else if (seq_idx_r == 3'd7) begin
                    state_s   = SEQ_IDLE;
                    seq_idx_s = 3'd0;
                end else begin
                    seq_idx_s = seq_idx_r + 3'd1;
                end
            end
            default: begin
                state_s   = SEQ_IDLE;
                seq_idx_s = 3'd0;
            end
        endcase
    end

    // Coefficient select: row j for DCT, column j (transpose) for IDCT
    always_comb begin
        for (int m = 0; m < N; m++) begin
            coeff_sel_s[m] = (work_mode_r == MODE_DCT) ? coeff_tab[seq_idx_r][m]
                                                       : coeff_tab[m][seq_idx_r];
        end
    end

    dct8_dot8 #(
        .DATA_W  (DATA_W),
        .COEFF_W (COEFF_W),
        .OUT_W   (OUT_W)
    ) u_dot8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_s),
        .in_index  (seq_idx_r),
        .x         (working_r),
        .c         (coeff_sel_s),
        .out_valid (bus.valid_out),
        .out_index (bus.index_out),
        .out_value (bus.coeff_out)
    );

endmodule

// File: tb/tb_dct_idct_8pt_pipeline.sv
// Self-checking bench: two engines (18-bit and 12-bit outputs) driven with
// identical stimulus and compared cycle by cycle against a real-valued
// cosine reference model with an output schedule.
module tb_dct_idct_8pt_pipeline;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dct_idct_8pt_pipeline_if #(.DATA_W(12), .OUT_W(18)) bus_a ();
    dct_idct_8pt_pipeline_if #(.DATA_W(12), .OUT_W(12)) bus_b ();

    dct_idct_8pt_pipeline #(.DATA_W(12), .COEFF_W(16), .OUT_W(18)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a));
    dct_idct_8pt_pipeline #(.DATA_W(12), .COEFF_W(16), .OUT_W(12)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b));

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     cmat [8][8];
    int     mbuf [8];
    bit     exp_v [4096];
    longint exp_y [4096];
    int     exp_i [4096];
    longint obs_a [8];
    longint obs_b [8];
    int     n_valid;
    int     first_v;
    int     last_close;
    int     ord_seq [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int     ord_mix [8] = '{3, 0, 1, 2, 4, 5, 6, 7};
    int     xv [8];

    task automatic chk(input string tag, input longint got, input longint want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // y[j] = sum C*x with the matrix transposed for the inverse, half-up rounding
    function automatic longint ref_y(input int j, input bit md, input int x [8]);
        longint acc;
        acc = 0;
        for (int m = 0; m < 8; m++) begin
            if (md) acc += longint'(cmat[m][j]) * x[m];
            else    acc += longint'(cmat[j][m]) * x[m];
        end
        return (acc + 64'sd8192) >>> 14;
    endfunction

    task automatic schedule(input int e, input bit md);
        for (int j = 0; j < 8; j++) begin
            exp_v[e + 3 + j] = 1'b1;
            exp_y[e + 3 + j] = ref_y(j, md, mbuf);
            exp_i[e + 3 + j] = j;
        end
    endtask

    task automatic clear_obs();
        n_valid = 0;
        first_v = -1;
        for (int j = 0; j < 8; j++) begin
            obs_a[j] = 64'sd99999;
            obs_b[j] = 64'sd99999;
        end
    endtask

    task automatic check_cycle();
        if (bus_a.valid_out) begin
            obs_a[bus_a.index_out] = $signed(bus_a.coeff_out);
            n_valid++;
            if (first_v < 0) first_v = cyc;
        end
        if (bus_b.valid_out) obs_b[bus_b.index_out] = $signed(bus_b.coeff_out);
        if (exp_v[cyc]) begin
            chk("valid_a", bus_a.valid_out, 1);
            chk("index_a", bus_a.index_out, exp_i[cyc]);
            chk("coeff_a", $signed(bus_a.coeff_out), sat(exp_y[cyc], 18));
            chk("valid_b", bus_b.valid_out, 1);
            chk("coeff_b", $signed(bus_b.coeff_out), sat(exp_y[cyc], 12));
        end else begin
            chk("idle_a", bus_a.valid_out, 0);
            chk("idle_b", bus_b.valid_out, 0);
        end
    endtask

    task automatic step(input bit v, input bit md, input int idx, input int s);
        bus_a.valid_in  = v;        bus_b.valid_in  = v;
        bus_a.mode      = md;       bus_b.mode      = md;
        bus_a.index     = idx[2:0]; bus_b.index     = idx[2:0];
        bus_a.sample_in = s[11:0];  bus_b.sample_in = s[11:0];
        @(posedge clk);
        cyc++;
        if (v) begin
            mbuf[idx] = s;
            if (idx == 7) begin
                last_close = cyc;
                schedule(cyc, md);
            end
        end
        #1;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic send_frame(input bit md, input int x [8], input int ord [8]);
        clear_obs();
        for (int i = 0; i < 8; i++) step(1'b1, md, ord[i], x[ord[i]]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus_a.valid_out, 0);
        chk({tag, "_coeff"}, $signed(bus_a.coeff_out), 0);
        chk({tag, "_index"}, bus_a.index_out, 0);
        chk({tag, "_valid_b"}, bus_b.valid_out, 0);
    endtask

    task automatic do_reset();
        bus_a.valid_in = 1'b0; bus_b.valid_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        for (int j = 0; j < 8; j++) mbuf[j] = 0;
        for (int c = cyc + 1; c < 4096; c++) exp_v[c] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            check_reset_outputs("rst_hold");
        end
        rst = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                real ck;
                real r;
                ck = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                r  = ck * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0) * 16384.0;
                cmat[k][n] = $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
            end
        end
        for (int c = 0; c < 4096; c++) exp_v[c] = 1'b0;
        for (int j = 0; j < 8; j++) mbuf[j] = 0;
        last_close = 0;
        clear_obs();
        bus_a.valid_in = 1'b0; bus_a.mode = 1'b0; bus_a.index = 3'd0; bus_a.sample_in = 12'sd0;
        bus_b.valid_in = 1'b0; bus_b.mode = 1'b0; bus_b.index = 3'd0; bus_b.sample_in = 12'sd0;

        do_reset();
        idle(3);

        // DC frame, forward
        for (int j = 0; j < 8; j++) xv[j] = 100;
        send_frame(1'b0, xv, ord_seq);
        idle(12);
        chk("dc_dct_k0", obs_a[0], 283);
        for (int j = 1; j < 8; j++) chk("dc_dct_ac", obs_a[j], 0);
        chk("dc_first_valid_offset", first_v - last_close, 3);
        chk("dc_valid_count", n_valid, 8);

        // DC frame, inverse
        xv = '{283, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b1, xv, ord_seq);
        idle(12);
        for (int j = 0; j < 8; j++) chk("dc_idct", obs_a[j], 100);

        // Ramp forward, then inverse of the 12-bit truncated result
        xv = '{0, 1, 2, 3, 4, 5, 6, 7};
        send_frame(1'b0, xv, ord_seq);
        idle(12);
        chk("ramp_k0", obs_a[0], 10);
        chk("ramp_k1", obs_a[1], -6);
        for (int j = 0; j < 8; j++) begin
            logic signed [11:0] t;
            longint tl;
            tl = obs_a[j];
            t  = tl[11:0];
            xv[j] = int'(t);
        end
        send_frame(1'b1, xv, ord_seq);
        idle(12);
        for (int j = 0; j < 8; j++) begin
            longint d;
            d = obs_a[j] - j;
            chk("roundtrip_within_1", ((d >= -1) && (d <= 1)) ? 1 : 0, 1);
        end

        // Out-of-order, negative full scale
        for (int j = 0; j < 8; j++) xv[j] = -2048;
        send_frame(1'b0, xv, ord_mix);
        idle(12);
        chk("neg_k0", obs_a[0], -5793);
        chk("neg_k3", obs_a[3], 0);
        chk("neg_valid_count", n_valid, 8);

        // Positive full scale: the 12-bit engine must clamp
        for (int j = 0; j < 8; j++) xv[j] = 2047;
        send_frame(1'b0, xv, ord_seq);
        idle(12);
        chk("sat_b_k0", obs_b[0], 2047);
        chk("nosat_a_k0", obs_a[0], 5790);

        // Back-to-back frames with no gap
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 8; j++) xv[j] = $urandom_range(0, 4095) - 2048;
            send_frame(1'(f), xv, ord_seq);
        end
        idle(12);

        // Random traffic: partial frames, early closes (restarts), mixed modes
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7), $urandom_range(0, 4095) - 2048);
        end
        idle(12);

        // Reset in the middle of an output burst: nothing more may appear
        for (int j = 0; j < 8; j++) xv[j] = $urandom_range(0, 4095) - 2048;
        send_frame(1'b0, xv, ord_seq);
        idle(5);
        do_reset();
        clear_obs();
        idle(15);
        chk("post_reset_no_output", n_valid, 0);

        // Reset left the buffer cleared: a lone index-7 sample forms the frame
        step(1'b1, 1'b0, 7, 800);
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
